// File: rtl/sequence_generator.sv
// Serial frame transmitter: preamble 1,0,0 then a zero-stuffed WIDTH-bit payload (MSB first)
// on line X, so a "100" detector on X fires exactly once per frame.
module sequence_generator #(
    parameter int WIDTH     = 8,
    parameter int BIT_TICKS = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA,
    output logic             X,
    output logic             BUSY,
    output logic             DONE
);

    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0]    IDLE = 2'd0;
    localparam logic [1:0]    PRE  = 2'd1;
    localparam logic [1:0]    PAY  = 2'd2;

    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);

    // A stuffed 1 is needed when the line just drove 1,0 and the next payload bit is 0.
    function automatic logic stuff_needed(input logic [1:0] hist, input logic next_bit);
        return (hist == 2'b10) && (next_bit == 1'b0);
    endfunction

    logic [1:0]       state_r,   state_s;
    logic [TW-1:0]    tick_r,    tick_s;
    logic [1:0]       pre_cnt_r, pre_cnt_s;
    logic [CW-1:0]    rem_r,     rem_s;
    logic [WIDTH-1:0] shreg_r,   shreg_s;
    logic [1:0]       hist_r,    hist_s;
    logic             x_r,       x_s;
    logic             busy_r,    busy_s;
    logic             done_r,    done_s;

    logic             boundary_s;
    logic             stuff_s;
    logic             pay_bit_s;
    logic [WIDTH-1:0] shreg_pay_s;
    logic [CW-1:0]    rem_pay_s;

    assign boundary_s  = (tick_r == TICK_LAST);
    assign stuff_s     = stuff_needed(hist_r, shreg_r[WIDTH-1]);
    assign pay_bit_s   = stuff_s ? 1'b1 : shreg_r[WIDTH-1];
    assign shreg_pay_s = stuff_s ? shreg_r : {shreg_r[WIDTH-2:0], 1'b0};
    assign rem_pay_s   = stuff_s ? rem_r : (rem_r - CW'(1));

    // Next-state logic: frame acceptance, preamble emission and payload bit selection.
    always_comb begin
        state_s   = state_r;
        tick_s    = tick_r;
        pre_cnt_s = pre_cnt_r;
        rem_s     = rem_r;
        shreg_s   = shreg_r;
        hist_s    = hist_r;
        x_s       = x_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                x_s = 1'b1;
                if (START) begin
                    state_s   = PRE;
                    tick_s    = {TW{1'b0}};
                    pre_cnt_s = 2'd0;
                    rem_s     = CNT_FULL;
                    shreg_s   = DATA;
                    hist_s    = 2'b11;
                    busy_s    = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            PRE: begin
                if (!boundary_s) begin
                    tick_s = tick_r + TW'(1);
                end else if (pre_cnt_r != 2'd2) begin
                    tick_s    = {TW{1'b0}};
                    pre_cnt_s = pre_cnt_r + 2'd1;
                    x_s       = 1'b0;
                    hist_s    = {hist_r[0], 1'b0};
                end else begin
                    // History is "00" here, so the first payload bit is never stuffed.
                    tick_s  = {TW{1'b0}};
                    state_s = PAY;
                    x_s     = pay_bit_s;
                    hist_s  = {hist_r[0], pay_bit_s};
                    shreg_s = shreg_pay_s;
                    rem_s   = rem_pay_s;
                end
            end
            PAY: begin
                if (!boundary_s) begin
                    tick_s = tick_r + TW'(1);
                end else if (rem_r == {CW{1'b0}}) begin
                    tick_s  = {TW{1'b0}};
                    state_s = IDLE;
                    x_s     = 1'b1;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    tick_s  = {TW{1'b0}};
                    x_s     = pay_bit_s;
                    hist_s  = {hist_r[0], pay_bit_s};
                    shreg_s = shreg_pay_s;
                    rem_s   = rem_pay_s;
                end
            end
            default: begin
                state_s = IDLE;
                x_s     = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= IDLE;
            tick_r    <= {TW{1'b0}};
            pre_cnt_r <= 2'd0;
            rem_r     <= {CW{1'b0}};
            shreg_r   <= {WIDTH{1'b0}};
            hist_r    <= 2'b00;
            x_r       <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            tick_r    <= tick_s;
            pre_cnt_r <= pre_cnt_s;
            rem_r     <= rem_s;
            shreg_r   <= shreg_s;
            hist_r    <= hist_s;
            x_r       <= x_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign X    = x_r;
    assign BUSY = busy_r;
    assign DONE = done_r;

endmodule
